// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD datapath blocks (bin_to_bcd_seq, bcd_adder,
// dabble_digit).
//   bcd_t            one packed BCD digit (4 bits, legal values 0..9)
//   BCD_MAX          largest legal digit value
//   DABBLE_THRESHOLD digit value at which double dabble adds 3 before a shift
//   state_t          control states of the sequential binary-to-BCD converter
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX          = 4'd9;
  localparam bcd_t DABBLE_THRESHOLD = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : bcd_pkg

// File: rtl/dabble_digit.sv
// ---------------------------------------------------------------------------
// dabble_digit
// Combinational shift-and-add-3 correction for a single BCD digit. A digit
// of 5 or more would become 10 or more after the next left shift, so 3 is
// added first. The shift then carries the excess into the next digit.
// Ports:
//   d_in   in   bcd_t   digit before correction
//   d_out  out  bcd_t   corrected digit (d_in >= 5 ? d_in + 3 : d_in)
// ---------------------------------------------------------------------------
module dabble_digit
  import bcd_pkg::*;
(
  input  bcd_t d_in,
  output bcd_t d_out
);

  // Inputs are always legal digits (0..9), so d_in + 3 is at most 12.
  // It never carries out of the 4-bit result.
  always_comb begin
    d_out = d_in;
    if (d_in >= DABBLE_THRESHOLD) begin
      d_out = bcd_t'(d_in + 4'd3);
    end
  end

endmodule : dabble_digit

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (double dabble). The block performs one
// correct-then-shift step per clock and takes WIDTH steps per word. Each
// result is held until the consumer takes it.
// Parameters:
//   WIDTH   binary input width, also the number of shift steps
//   DIGITS  number of BCD output digits
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          bin_in is valid
//   in_ready   out  1          converter idle, word can be accepted
//   bin_in     in   WIDTH      unsigned value to convert
//   out_valid  out  1          bcd_out holds a finished result
//   out_ready  in   1          consumer accepts bcd_out
//   bcd_out    out  DIGITS*4   digit i at [4i+3:4i], digit 0 is the LSD
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = DIGITS * 4;

  // The digits must cover the full binary range, both in bit count and in
  // decimal magnitude. Because of this check, no overflow flag is needed.
  if ((BW < WIDTH) || ((10 ** DIGITS) <= ((2 ** WIDTH) - 1))) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS=%0d cannot represent WIDTH=%0d", DIGITS, WIDTH);
  end

  state_t           state;
  state_t           next_state;
  logic [BW-1:0]    digits;
  logic [BW-1:0]    corrected;
  logic [BW-1:0]    shifted_digits;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]    count;
  logic             last_step;

  // One correction cell per digit. These cells run in parallel on the
  // current digit registers.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    dabble_digit u_dabble_digit (
      .d_in  (digits[4*g +: 4]),
      .d_out (corrected[4*g +: 4])
    );
  end

  // Correction happens before the shift. The binary MSB enters digit 0 bit 0.
  assign shifted_digits = {corrected[BW-2:0], bin[WIDTH-1]};
  assign last_step      = (state == SHIFT) && (count == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are decoded directly from the state flops.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Conversion datapath. bcd_out is loaded only on the final step, so it
  // keeps the previous result while a new word converts and stays stable
  // throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits  <= '0;
      bin     <= '0;
      count   <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin    <= bin_in;
            digits <= '0;
            count  <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          digits <= shifted_digits;
          bin    <= {bin[WIDTH-2:0], 1'b0};
          count  <= count - CW'(1);
          if (last_step) begin
            bcd_out <= shifted_digits;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : bin_to_bcd_seq
